ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit for the single-cycle MIPS core: holds the program counter, computes the next PC from sequential/branch/jump/jump-register selects, and drives the word address into the instruction memory `im`, which it reads combinationally. It sits at the head of the datapath. It also detects illegal fetch targets and freezes fetch with a sticky fault, and it keeps a retired-fetch counter for debug.

## Interface
- `PC_RESET`, 32'h0000_3000: PC value after reset and base of instruction memory.
- `IM_WORDS`, 1024: instruction memory depth in words (power of two).
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: synchronous, active-high.
- `stall` input, 1: hold the PC this cycle.
- `npc_sel` input, 2: next-PC select: 0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr.
- `br_taken` input, 1: branch condition from the comparator; used only when `npc_sel`=1.
- `imm16` input, 16: branch offset field.
- `imm26` input, 26: jump index field.
- `jr_target` input, 32: register value for jr.
- `instr` input, 32: word returned by `im` for `im_addr`.
- `pc` output, 32: current PC.
- `pc4` output, 32: PC+4, the jal link value.
- `im_addr` output, log2(IM_WORDS): word index into `im`.
- `instr_out` output, 32: fetched instruction. Equals `instr` unless `fault`=1, then 32'h0 (nop).
- `fault` output, 1: sticky illegal-fetch flag.
- `fault_pc` output, 32: offending next-PC target, captured on fault entry.
- `fetch_cnt` output, 32: number of committed PC updates.

## Operation
- Next-PC (`npc`):
  - sel 0: PC+4.
  - sel 1: `br_taken` ? PC+4+(sext(imm16)<<2) : PC+4.
  - sel 2: {pc4[31:28], imm26, 2'b00}.
  - sel 3: `jr_target`.
  - All arithmetic is mod 2^32; overflow wraps silently and is then range-checked.
- Legality check: `npc` is legal iff `npc[1:0]`==0 and PC_RESET ≤ npc < PC_RESET+4*IM_WORDS.
- States: RUN and FAULT.
- RUN:
  - stall=1: PC, counter and fault unchanged.
  - stall=0 and `npc` legal: PC←npc, `fetch_cnt`+1.
  - stall=0 and `npc` illegal: PC unchanged, `fault`←1, `fault_pc`←npc, move to FAULT. The counter does not increment.
- FAULT: PC, counter and `fault_pc` are frozen, `instr_out`=0. Inputs are ignored. Only `reset` leaves this state.
- Priority: reset > FAULT > stall > update.
- `im_addr` = (pc − PC_RESET)[log2(IM_WORDS)+1:2].
- `fetch_cnt` wraps from 32'hFFFF_FFFF to 0.
- Reset values: pc=PC_RESET, pc4=PC_RESET+4, im_addr=0, fault=0, fault_pc=0, fetch_cnt=0, state RUN.

## Timing
- The PC updates on the rising edge. `im_addr`, `pc4` and `instr_out` are combinational from the current PC, giving zero-cycle fetch latency, as the single-cycle core requires.
- A branch, jump or jr takes effect on the edge that ends the cycle in which the select is presented. There are no delay slots.
- Fault entry is flagged on the same edge the illegal update would have occurred. `fault` reads 1 in the following cycle.
- Stall and an illegal `npc` in the same cycle: stall wins and no fault is raised.
- Reset asserted mid-operation, including in FAULT: on the next edge all state returns to reset values regardless of stall or select.
- The last legal word is PC_RESET+4*IM_WORDS−4 (0x3FFC at defaults). Sequential fetch beyond it faults.

## Structure
- Shared package `mips_pkg`:
  - NPC_PC4/NPC_BR/NPC_J/NPC_JR codes.
  - PC_RESET_DEFAULT.
  - IM_WORDS_DEFAULT.
- Sub-module `npc`: the purely combinational next-PC and legality computation (inputs pc, sel, br_taken, imm16, imm26, jr_target; outputs npc, pc4, legal).
- `ifu_fetch` holds the PC, state, fault capture and counter registers, and instantiates `im` alongside.

## Test plan
- Reset then 3 unstalled sel-0 cycles → pc 0x3000→0x3004→0x3008→0x300C; im_addr 3; fetch_cnt 3.
- pc=0x3010, sel 1, imm16=16'hFFFC: br_taken=1 → pc 0x3004; br_taken=0 → 0x3014.
- pc=0x3010, sel 2, imm26=26'h0000C10 → pc 0x3040. Then sel 3, jr_target 0x3100 → pc 0x3100. Check pc4 before each jump.
- Stall held 4 cycles with sel 3 and jr_target 0x3002 → pc frozen, fault stays 0. Release stall → fault 1, fault_pc 0x3002, pc unchanged, instr_out 0.
- pc=0x3FFC, sel 0 → fault 1, fault_pc 0x4000. A following legal jr 0x3000 is ignored. Reset → pc 0x3000, fault 0, fetch_cnt 0.
- Reset asserted together with stall=1 and a taken branch → on the next edge pc=0x3000, and the counter is cleared.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared next-PC select codes, fetch defaults and fetch state type
package mips_pkg;

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int          IM_WORDS_DEFAULT = 1024;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/npc.sv
// rtl/npc.sv - combinational next-PC selection and fetch-target legality check
module npc
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic [1:0]  sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    output logic [31:0] npc,
    output logic [31:0] pc4,
    output logic        legal
);

    // Bounds are held in 33 bits so the upper limit cannot wrap at the top of the address space.
    localparam logic [32:0] PC_LO    = {1'b0, PC_RESET};
    localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) << 2;
    localparam logic [32:0] PC_HI    = PC_LO + IM_BYTES;

    logic [31:0] br_off;

    always_comb begin
        pc4    = pc + 32'd4;
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        npc    = pc4;
        case (sel)
            NPC_PC4: npc = pc4;
            NPC_BR:  npc = br_taken ? (pc4 + br_off) : pc4;
            NPC_J:   npc = {pc4[31:28], imm26, 2'b00};
            NPC_JR:  npc = jr_target;
            default: npc = pc4;
        endcase
        legal = (npc[1:0] == 2'b00)
             && ({1'b0, npc} >= PC_LO)
             && ({1'b0, npc} <  PC_HI);
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - program counter, sticky fetch fault and retired-fetch counter
module ifu_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_WORDS = IM_WORDS_DEFAULT,
    localparam int         IM_AW    = $clog2(IM_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       npc_sel,
    input  logic             br_taken,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic [31:0]      jr_target,
    input  logic [31:0]      instr,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      instr_out,
    output logic             fault,
    output logic [31:0]      fault_pc,
    output logic [31:0]      fetch_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [31:0]  npc_val;
    logic         npc_legal;
    logic [31:0]  pc_off;

    npc #(
        .PC_RESET (PC_RESET),
        .IM_WORDS (IM_WORDS)
    ) u_npc (
        .pc        (pc_q),
        .sel       (npc_sel),
        .br_taken  (br_taken),
        .imm16     (imm16),
        .imm26     (imm26),
        .jr_target (jr_target),
        .npc       (npc_val),
        .pc4       (pc4),
        .legal     (npc_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= PC_RESET;
            fault_pc_q <= 32'h0;
            cnt_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    // FAULT is absorbing; stall outranks the legality check so a stalled bad target never faults.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (npc_legal) begin
                        pc_d  = npc_val;
                        cnt_d = cnt_q + 32'd1;
                    end else begin
                        fault_pc_d = npc_val;
                        state_d    = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        pc_off    = pc_q - PC_RESET;
        im_addr   = IM_AW'(pc_off >> 2);
        pc        = pc_q;
        fault     = (state_q == ST_FAULT);
        instr_out = fault ? 32'h0 : instr;
        fault_pc  = fault_pc_q;
        fetch_cnt = cnt_q;
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed scoreboard bench for ifu_fetch
module tb_ifu_fetch;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [9:0]  im_addr;
        logic [31:0] instr_out;
        logic        fault;
        logic [31:0] fault_pc;
        logic [31:0] fetch_cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_target;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [9:0]  im_addr;
    logic [31:0] instr_out;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    bit   done = 1'b0;

    ifu_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .imm16     (imm16),
        .imm26     (imm26),
        .jr_target (jr_target),
        .instr     (instr),
        .pc        (pc),
        .pc4       (pc4),
        .im_addr   (im_addr),
        .instr_out (instr_out),
        .fault     (fault),
        .fault_pc  (fault_pc),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory stand-in: each word tags its own index.
    assign instr = 32'hA500_0000 | {22'h0, im_addr};

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
        end
    endtask

    // Monitor: state settles after each rising edge; compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.name, "pc",        pc,               e.pc);
            chk(e.name, "pc4",       pc4,              e.pc4);
            chk(e.name, "im_addr",   {22'h0, im_addr}, {22'h0, e.im_addr});
            chk(e.name, "instr_out", instr_out,        e.instr_out);
            chk(e.name, "fault",     {31'h0, fault},   {31'h0, e.fault});
            chk(e.name, "fault_pc",  fault_pc,         e.fault_pc);
            chk(e.name, "fetch_cnt", fetch_cnt,        e.fetch_cnt);
        end
    end

    // Apply one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input string name, input logic rst, input logic stl, input logic [1:0] sel,
                        input logic br, input logic [15:0] i16, input logic [25:0] i26,
                        input logic [31:0] jr, input logic [31:0] e_pc, input logic e_fault,
                        input logic [31:0] e_fpc, input logic [31:0] e_cnt);
        exp_t        e;
        logic [31:0] off;
        @(negedge clk);
        reset     = rst;
        stall     = stl;
        npc_sel   = sel;
        br_taken  = br;
        imm16     = i16;
        imm26     = i26;
        jr_target = jr;
        off         = e_pc - 32'h3000;
        e.name      = name;
        e.pc        = e_pc;
        e.pc4       = e_pc + 32'd4;
        e.im_addr   = off[11:2];
        e.instr_out = e_fault ? 32'h0 : (32'hA500_0000 | {22'h0, off[11:2]});
        e.fault     = e_fault;
        e.fault_pc  = e_fpc;
        e.fetch_cnt = e_cnt;
        sb_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; npc_sel = 2'd0; br_taken = 1'b0;
        imm16 = 16'h0; imm26 = 26'h0; jr_target = 32'h0;

        //    name          rst  stl  sel  br   imm16     imm26         jr            pc            flt   fault_pc      cnt
        step("reset",       1,   0,   0,   0,   16'h0,    26'h0,        32'h0,        32'h3000,     0,    32'h0,        0);
        step("seq1",        0,   0,   0,   0,   16'h0,    26'h0,        32'h0,        32'h3004,     0,    32'h0,        1);
        step("seq2",        0,   0,   0,   0,   16'h0,    26'h0,        32'h0,        32'h3008,     0,    32'h0,        2);
        step("seq3",        0,   0,   0,   0,   16'h0,    26'h0,        32'h0,        32'h300C,     0,    32'h0,        3);
        step("jr3010a",     0,   0,   3,   0,   16'h0,    26'h0,        32'h3010,     32'h3010,     0,    32'h0,        4);
        step("br_taken",    0,   0,   1,   1,   16'hFFFC, 26'h0,        32'h0,        32'h3004,     0,    32'h0,        5);
        step("jr3010b",     0,   0,   3,   0,   16'h0,    26'h0,        32'h3010,     32'h3010,     0,    32'h0,        6);
        step("br_not",      0,   0,   1,   0,   16'hFFFC, 26'h0,        32'h0,        32'h3014,     0,    32'h0,        7);
        step("jr3010c",     0,   0,   3,   0,   16'h0,    26'h0,        32'h3010,     32'h3010,     0,    32'h0,        8);
        step("jump",        0,   0,   2,   0,   16'h0,    26'h0000C10,  32'h0,        32'h3040,     0,    32'h0,        9);
        step("jr3100",      0,   0,   3,   0,   16'h0,    26'h0,        32'h3100,     32'h3100,     0,    32'h0,        10);
        for (int i = 0; i < 4; i++)
            step("stall_bad", 0, 1,   3,   0,   16'h0,    26'h0,        32'h3002,     32'h3100,     0,    32'h0,        10);
        step("misalign",    0,   0,   3,   0,   16'h0,    26'h0,        32'h3002,     32'h3100,     1,    32'h3002,     10);
        step("flt_hold",    0,   0,   0,   0,   16'h0,    26'h0,        32'h0,        32'h3100,     1,    32'h3002,     10);
        step("reset2",      1,   0,   0,   0,   16'h0,    26'h0,        32'h0,        32'h3000,     0,    32'h0,        0);
        step("jr_last",     0,   0,   3,   0,   16'h0,    26'h0,        32'h3FFC,     32'h3FFC,     0,    32'h0,        1);
        step("seq_over",    0,   0,   0,   0,   16'h0,    26'h0,        32'h0,        32'h3FFC,     1,    32'h4000,     1);
        step("flt_jr",      0,   0,   3,   0,   16'h0,    26'h0,        32'h3000,     32'h3FFC,     1,    32'h4000,     1);
        step("flt_stall",   0,   1,   3,   0,   16'h0,    26'h0,        32'h3000,     32'h3FFC,     1,    32'h4000,     1);
        step("reset3",      1,   0,   3,   0,   16'h0,    26'h0,        32'h3000,     32'h3000,     0,    32'h0,        0);
        step("seq4",        0,   0,   0,   0,   16'h0,    26'h0,        32'h0,        32'h3004,     0,    32'h0,        1);
        step("seq5",        0,   0,   0,   0,   16'h0,    26'h0,        32'h0,        32'h3008,     0,    32'h0,        2);
        step("rst_stall",   1,   1,   1,   1,   16'hFFFC, 26'h0,        32'h0,        32'h3000,     0,    32'h0,        0);
        step("jr_below",    0,   0,   3,   0,   16'h0,    26'h0,        32'h2FFC,     32'h3000,     1,    32'h2FFC,     0);
        step("reset4",      1,   0,   0,   0,   16'h0,    26'h0,        32'h0,        32'h3000,     0,    32'h0,        0);
        step("br_back",     0,   0,   1,   1,   16'hFFFF, 26'h0,        32'h0,        32'h3000,     0,    32'h0,        1);

        @(negedge clk);
        reset = 1'b0; stall = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            begin
                #100000;
                checks++;
                errors++;
                $display("FAIL timeout: got no completion, expected completion within 100000 time units");
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
